// File: rtl/softproc_nios2_gen2_0_cpu_debug_slave_cmdq.sv
// softproc_nios2_gen2_0_cpu_debug_slave_cmdq
//
// System-clock half of the CPU debug slave. The JTAG update-DR and update-IR
// levels arrive from the TCK domain. Each one passes through a synchroniser, a
// history flop and a registered edge detector. Every update-DR event captures
// {ir_in, sr} into a small command queue. The OCI core drains the queue with a
// valid/ready handshake. Each popped command is decoded into a one-hot
// take_action or take_no_action pulse, and its DR is held on jdo.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   ir_in, sr         TCK-domain IR and DR, held stable around vs_udr
//   vs_udr, vs_uir    TCK-domain update-DR / update-IR levels
//   cmd_ready         consumer accepts the head command
//   clear_ovf         one-cycle clear of the sticky overflow flag
//   cmd_valid         queue non-empty
//   cmd_ir, cmd_dr    head command fields
//   jdo               DR of the most recently popped command
//   take_action       one-hot pulse, popped command with action bit set
//   take_no_action    one-hot pulse, popped command with action bit clear
//   ir_update         one-cycle pulse per synchronised vs_uir rise
//   overflow          sticky flag, an update-DR was dropped on a full queue
//   level             queue occupancy
module softproc_nios2_gen2_0_cpu_debug_slave_cmdq #(
  parameter int IR_WIDTH    = 2,
  parameter int DR_WIDTH    = 38,
  parameter int SYNC_STAGES = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [IR_WIDTH-1:0]                ir_in,
  input  logic [DR_WIDTH-1:0]                sr,
  input  logic                               vs_udr,
  input  logic                               vs_uir,
  input  logic                               cmd_ready,
  input  logic                               clear_ovf,
  output logic                               cmd_valid,
  output logic [IR_WIDTH-1:0]                cmd_ir,
  output logic [DR_WIDTH-1:0]                cmd_dr,
  output logic [DR_WIDTH-1:0]                jdo,
  output logic [2**IR_WIDTH-1:0]             take_action,
  output logic [2**IR_WIDTH-1:0]             take_no_action,
  output logic                               ir_update,
  output logic                               overflow,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   level
);

  localparam int NumCh   = 2**IR_WIDTH;
  localparam int PtrW    = $clog2(QUEUE_DEPTH);
  localparam int LevelW  = $clog2(QUEUE_DEPTH+1);
  localparam int EntryW  = IR_WIDTH + DR_WIDTH;

  logic [SYNC_STAGES-1:0] udrSync_q, uirSync_q;
  logic                   udrHist_q, uirHist_q;
  logic                   udrEvent_q, uirEvent_q;

  logic [EntryW-1:0]      mem_q [QUEUE_DEPTH];
  logic [PtrW-1:0]        wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [LevelW-1:0]      level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic [DR_WIDTH-1:0]    jdo_q, jdo_d;
  logic [NumCh-1:0]       takeAction_q, takeAction_d;
  logic [NumCh-1:0]       takeNoAction_q, takeNoAction_d;

  logic [EntryW-1:0]      headEntry;
  logic                   queueFull, pushReq, popReq, pushAccept, pushDrop;

  // Strobe synchronisers. The sync and history flops reset to 1. A strobe that
  // is already high when reset releases therefore looks like a steady level
  // and does not produce an edge. The edge detector is registered, so an event
  // appears SYNC_STAGES+1 clocks after the strobe rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udrSync_q  <= '1;
      uirSync_q  <= '1;
      udrHist_q  <= 1'b1;
      uirHist_q  <= 1'b1;
      udrEvent_q <= 1'b0;
      uirEvent_q <= 1'b0;
    end else begin
      udrSync_q  <= {udrSync_q[SYNC_STAGES-2:0], vs_udr};
      uirSync_q  <= {uirSync_q[SYNC_STAGES-2:0], vs_uir};
      udrHist_q  <= udrSync_q[SYNC_STAGES-1];
      uirHist_q  <= uirSync_q[SYNC_STAGES-1];
      udrEvent_q <= udrSync_q[SYNC_STAGES-1] & ~udrHist_q;
      uirEvent_q <= uirSync_q[SYNC_STAGES-1] & ~uirHist_q;
    end
  end

  assign headEntry  = mem_q[rdPtr_q];
  assign queueFull  = (level_q == LevelW'(QUEUE_DEPTH));
  assign pushReq    = udrEvent_q;
  assign popReq     = cmd_valid & cmd_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign pushAccept = pushReq & (~queueFull | popReq);
  assign pushDrop   = pushReq & queueFull & ~popReq;

  // Next-state logic for the queue pointers, occupancy, overflow flag and
  // pop-side decode. The pointers wrap naturally because the depth is a power
  // of two.
  always_comb begin
    wrPtr_d        = wrPtr_q + PtrW'(pushAccept);
    rdPtr_d        = rdPtr_q + PtrW'(popReq);
    level_d        = level_q + LevelW'(pushAccept) - LevelW'(popReq);
    overflow_d     = overflow_q;
    jdo_d          = jdo_q;
    takeAction_d   = '0;
    takeNoAction_d = '0;
    if (pushDrop) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end
    if (popReq) begin
      jdo_d = headEntry[DR_WIDTH-1:0];
      if (headEntry[DR_WIDTH-1]) begin
        takeAction_d = NumCh'(1) << headEntry[EntryW-1:DR_WIDTH];
      end else begin
        takeNoAction_d = NumCh'(1) << headEntry[EntryW-1:DR_WIDTH];
      end
    end
  end

  // Control and output registers. Outputs change only at a clock edge, and
  // reset clears them immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q        <= '0;
      rdPtr_q        <= '0;
      level_q        <= '0;
      overflow_q     <= 1'b0;
      jdo_q          <= '0;
      takeAction_q   <= '0;
      takeNoAction_q <= '0;
    end else begin
      wrPtr_q        <= wrPtr_d;
      rdPtr_q        <= rdPtr_d;
      level_q        <= level_d;
      overflow_q     <= overflow_d;
      jdo_q          <= jdo_d;
      takeAction_q   <= takeAction_d;
      takeNoAction_q <= takeNoAction_d;
    end
  end

  // Queue storage has no reset. Its contents are meaningless while the queue
  // is empty, and the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (pushAccept) begin
      mem_q[wrPtr_q] <= {ir_in, sr};
    end
  end

  assign cmd_valid      = (level_q != '0);
  assign cmd_ir         = headEntry[EntryW-1:DR_WIDTH];
  assign cmd_dr         = headEntry[DR_WIDTH-1:0];
  assign jdo            = jdo_q;
  assign take_action    = takeAction_q;
  assign take_no_action = takeNoAction_q;
  assign ir_update      = uirEvent_q;
  assign overflow       = overflow_q;
  assign level          = level_q;

endmodule

// File: tb/tb_softproc_nios2_gen2_0_cpu_debug_slave_cmdq.sv
module tb_softproc_nios2_gen2_0_cpu_debug_slave_cmdq;

  localparam int IrW    = 2;
  localparam int DrW    = 38;
  localparam int NumCh  = 4;
  localparam int LevelW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [IrW-1:0]    ir_in;
  logic [DrW-1:0]    sr;
  logic              vs_udr, vs_uir, cmd_ready, clear_ovf;
  logic              cmd_valid;
  logic [IrW-1:0]    cmd_ir;
  logic [DrW-1:0]    cmd_dr, jdo;
  logic [NumCh-1:0]  take_action, take_no_action;
  logic              ir_update, overflow;
  logic [LevelW-1:0] level;

  softproc_nios2_gen2_0_cpu_debug_slave_cmdq #(
    .IR_WIDTH(IrW), .DR_WIDTH(DrW), .SYNC_STAGES(2), .QUEUE_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready), .clear_ovf(clear_ovf),
    .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action),
    .ir_update(ir_update), .overflow(overflow), .level(level)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  typedef struct {
    logic [IrW-1:0]   ir;
    logic [DrW-1:0]   dr;
    logic [NumCh-1:0] act;
    logic [NumCh-1:0] noAct;
  } cmd_t;

  cmd_t sbq[$];
  cmd_t vectors[6];
  cmd_t t3[5];
  cmd_t extra;
  int   errors = 0;
  int   checks = 0;
  bit   popPending = 1'b0;

  // Reference decode: the top DR bit selects the vector, and the IR selects the channel
  function automatic cmd_t modelCmd(input logic [IrW-1:0] ir, input logic [DrW-1:0] dr);
    cmd_t c;
    c.ir    = ir;
    c.dr    = dr;
    c.act   = dr[DrW-1] ? (NumCh'(1) << ir) : '0;
    c.noAct = dr[DrW-1] ? '0 : (NumCh'(1) << ir);
    return c;
  endfunction

  // Compare one value, bump the counters, report a failure line on mismatch
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Raise vs_udr with a command just after a clock edge; queue it as expected if it should be accepted
  task automatic raiseUdr(input cmd_t c, input bit accept);
    @(posedge clk); #2;
    ir_in  = c.ir;
    sr     = c.dr;
    vs_udr = 1'b1;
    if (accept) sbq.push_back(c);
  endtask

  // Lower vs_udr and let the synchroniser settle
  task automatic dropUdr();
    @(posedge clk); #2;
    vs_udr = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // One full update-DR transfer, optionally checking the push latency on an empty queue
  task automatic applyStimulus(input cmd_t c, input bit accept, input bit latencyCheck);
    raiseUdr(c, accept);
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (latencyCheck && i == 3) checkOutput("valid_early", cmd_valid, 0);
      if (latencyCheck && i == 4) begin
        checkOutput("valid_at_4", cmd_valid, 1);
        checkOutput("head_ir", cmd_ir, c.ir);
        checkOutput("head_dr", cmd_dr, c.dr);
      end
    end
    dropUdr();
  endtask

  // Pop monitor: a handshake seen before a clock edge must show its decode
  // and jdo on the following cycle; otherwise both take vectors stay quiet
  always @(negedge clk) begin : popMonitor
    cmd_t e;
    if (reset) begin
      popPending = 1'b0;
    end else begin
      if (popPending) begin
        if (sbq.size() == 0) begin
          checkOutput("pop_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          checkOutput("jdo", jdo, e.dr);
          checkOutput("take_action", take_action, e.act);
          checkOutput("take_no_action", take_no_action, e.noAct);
        end
      end else begin
        checkOutput("take_idle", {take_action, take_no_action}, 0);
      end
      popPending = cmd_valid & cmd_ready;
    end
  end

  // Main sequence
  initial begin
    vectors[0] = '{2'd2, 38'h21_2345_6789, 4'b0100, 4'b0000};
    vectors[1] = '{2'd1, 38'h0A_BCDE_F012, 4'b0000, 4'b0010};
    vectors[2] = '{2'd0, 38'h20_0000_0001, 4'b0001, 4'b0000};
    vectors[3] = '{2'd3, 38'h1F_FFFF_FFFF, 4'b0000, 4'b1000};
    vectors[4] = '{2'd3, 38'h3F_FFFF_FFFF, 4'b1000, 4'b0000};
    vectors[5] = '{2'd0, 38'h00_0000_0000, 4'b0000, 4'b0001};
    for (int i = 0; i < 5; i++) t3[i] = modelCmd(IrW'(i), DrW'({$urandom(), $urandom()}));

    reset = 1'b1; ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0;
    cmd_ready = 1'b0; clear_ovf = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_outputs", {cmd_valid, jdo, take_action, take_no_action, ir_update, overflow, level}, 0);
    @(posedge clk); #2 reset = 1'b0;
    repeat (4) @(posedge clk);

    // Single commands drained immediately: latency and decode
    #2 cmd_ready = 1'b1;
    for (int v = 0; v < 6; v++) applyStimulus(vectors[v], 1'b1, 1'b1);
    @(posedge clk); #2 cmd_ready = 1'b0;

    // Five pushes without a consumer: the fifth is dropped
    for (int i = 0; i < 5; i++) applyStimulus(t3[i], i < 4, 1'b0);
    @(negedge clk);
    checkOutput("ovf_level", level, 4);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_head_ir", cmd_ir, t3[0].ir);
    checkOutput("ovf_head_dr", cmd_dr, t3[0].dr);

    // A clear that coincides with a new drop loses to the drop
    extra = modelCmd(2'd1, 38'h2A_AAAA_5555);
    raiseUdr(extra, 1'b0);
    repeat (3) @(posedge clk); #2 clear_ovf = 1'b1;
    @(posedge clk); #2 clear_ovf = 1'b0;
    @(negedge clk);
    checkOutput("clr_vs_drop", overflow, 1);
    checkOutput("clr_vs_drop_level", level, 4);
    repeat (3) @(posedge clk);
    dropUdr();

    // Plain clear
    @(posedge clk); #2 clear_ovf = 1'b1;
    @(posedge clk); #2 clear_ovf = 1'b0;
    @(negedge clk);
    checkOutput("ovf_cleared", overflow, 0);

    // Full queue with a push and a pop in the same cycle
    extra = modelCmd(2'd2, 38'h15_5555_AAAA);
    raiseUdr(extra, 1'b1);
    repeat (3) @(posedge clk); #2 cmd_ready = 1'b1;
    @(posedge clk); #2 cmd_ready = 1'b0;
    @(negedge clk);
    checkOutput("full_pp_level", level, 4);
    checkOutput("full_pp_ovf", overflow, 0);
    checkOutput("full_pp_head", cmd_dr, t3[1].dr);
    repeat (3) @(posedge clk);
    dropUdr();

    // Drain back-to-back; the monitor checks order and pulses
    @(posedge clk); #2 cmd_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_level", level, 0);
    checkOutput("drain_sb_empty", sbq.size(), 0);
    @(posedge clk); #2 cmd_ready = 1'b0;

    // Asynchronous reset with three entries queued and vs_udr high
    for (int i = 0; i < 3; i++) applyStimulus(modelCmd(IrW'(i + 1), DrW'({$urandom(), $urandom()})), 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("pre_rst_level", level, 3);
    raiseUdr(modelCmd(2'd3, 38'h3C_0000_0003), 1'b0);
    @(negedge clk); #1 reset = 1'b1;
    #1;
    checkOutput("async_rst_outputs", {cmd_valid, jdo, take_action, take_no_action, ir_update, overflow, level}, 0);
    sbq.delete();
    repeat (2) @(posedge clk); #2 reset = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("rst_release_level", level, 0);
    checkOutput("rst_release_valid", cmd_valid, 0);
    dropUdr();
    repeat (2) @(posedge clk);

    // vs_uir and vs_udr rising together
    extra = modelCmd(2'd3, 38'h33_1234_0F0F);
    @(posedge clk); #2;
    ir_in = extra.ir; sr = extra.dr; vs_udr = 1'b1; vs_uir = 1'b1;
    sbq.push_back(extra);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i == 2) checkOutput("uir_early", ir_update, 0);
      if (i == 3) begin
        checkOutput("uir_pulse", ir_update, 1);
        checkOutput("uir_level_before", level, 0);
      end
      if (i == 4) begin
        checkOutput("uir_pulse_end", ir_update, 0);
        checkOutput("uir_level_after", level, 1);
      end
    end
    @(posedge clk); #2 vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("uir_drain_level", level, 0);
    checkOutput("uir_sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
